// File: rtl/gain_pkg.sv
// Shared widths and constants for the gain scaler datapath.
// Constants are functions of width so every instance derives its own limits.
package gain_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int COEF_W_DEF = 32;
  localparam int FRAC_W_DEF = 30;

  // Fixed-point 1.0 for a coefficient with frac_w fractional bits.
  function automatic logic [63:0] unity(input int frac_w);
    return 64'd1 << frac_w;
  endfunction

  function automatic logic signed [127:0] sat_hi(input int data_w);
    return (128'sd1 <<< (data_w - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [127:0] sat_lo(input int data_w);
    return -(128'sd1 <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/gain_round_sat.sv
// Combinational round-half-up, arithmetic shift and clamp of a full-width product.
// The registered copy of the result lives in the parent.
module gain_round_sat
  import gain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic signed [DATA_W+COEF_W-1:0] prod,
  output logic signed [DATA_W-1:0]        res,
  output logic                            sat
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [PROD_W-1:0] HI = PROD_W'(sat_hi(DATA_W));
  localparam logic signed [PROD_W-1:0] LO = PROD_W'(sat_lo(DATA_W));

  logic signed [PROD_W-1:0] rnd;

  // The product has a spare sign bit, so adding the half-LSB never overflows.
  generate
    if (FRAC_W > 0) begin : g_round
      localparam logic signed [PROD_W-1:0] HALF = PROD_W'(64'd1) << (FRAC_W - 1);
      assign rnd = (prod + HALF) >>> FRAC_W;
    end else begin : g_pass
      assign rnd = prod;
    end
  endgenerate

  always_comb begin
    sat = 1'b0;
    res = rnd[DATA_W-1:0];
    if (rnd > HI) begin
      sat = 1'b1;
      res = HI[DATA_W-1:0];
    end else if (rnd < LO) begin
      sat = 1'b1;
      res = LO[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/gain_scaler_pipe.sv
// Three-stage signed gain stage: capture, multiply, round/saturate.
// Coefficient is double-buffered; bypass travels with each sample.
module gain_scaler_pipe
  import gain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic                     coef_load,
  input  logic                     bypass_en,
  input  logic                     sat_clr,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic signed [COEF_W-1:0] coef_active,
  output logic                     sat_flag
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(unity(FRAC_W));

  logic signed [COEF_W-1:0] coef_shadow;
  logic signed [COEF_W-1:0] coef_act;
  logic                     coef_pending;
  logic signed [COEF_W-1:0] coef_eff;

  logic                     v1, b1;
  logic signed [DATA_W-1:0] d1;
  logic signed [COEF_W-1:0] c1;

  logic                     v2, b2;
  logic signed [DATA_W-1:0] d2;
  logic signed [PROD_W-1:0] p2;

  logic signed [DATA_W-1:0] rs_res;
  logic                     rs_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      coef_shadow  <= COEF_ONE;
      coef_act     <= COEF_ONE;
      coef_pending <= 1'b0;
    end else begin
      coef_pending <= coef_load;
      if (coef_load) coef_shadow <= coef_in;
      if (coef_pending) coef_act <= coef_shadow;
    end
  end

  // While a load is pending the shadow value is already the one new samples get.
  assign coef_eff    = coef_pending ? coef_shadow : coef_act;
  assign coef_active = coef_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        d1 <= in_data;
        c1 <= coef_eff;
        b1 <= bypass_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        p2 <= PROD_W'(d1) * PROD_W'(c1);
        d2 <= d1;
        b2 <= b1;
      end
    end
  end

  gain_round_sat #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .FRAC_W(FRAC_W)
  ) u_round_sat (
    .prod(p2),
    .res (rs_res),
    .sat (rs_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) out_data <= b2 ? d2 : rs_res;
      // A new saturation outranks a simultaneous clear.
      if (v2 && !b2 && rs_sat) sat_flag <= 1'b1;
      else if (sat_clr)        sat_flag <= 1'b0;
    end
  end

endmodule

// File: doc/gain_scaler_pipe.md
# gain_scaler_pipe

Parametrised successor to the fixed unity-gain 64-bit signed pass-through stage. It multiplies each signed sample by a runtime-programmable signed fixed-point coefficient, then rounds and saturates back to sample width. Results come out through a fixed-latency valid pipeline. It sits in the anti-noise path between the adaptive filter output and the actuator DAC formatter, and provides exact bypass (gain = 1) for calibration.

## Interface
- DATA_W, 64, sample width (signed two's complement)
- COEF_W, 32, coefficient width (signed)
- FRAC_W, 30, coefficient fractional bits; legal range 0 ≤ FRAC_W ≤ COEF_W-2, so that 1.0 is representable
- clk  in  1  sole clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample strobe
- in_data  in  DATA_W  signed sample
- coef_in  in  COEF_W  new coefficient
- coef_load  in  1  single-cycle pulse; writes coef_in to the shadow register
- bypass_en  in  1  when 1, the output equals the input exactly
- sat_clr  in  1  clears the sticky saturation flag
- out_valid  out  1  result strobe
- out_data  out  DATA_W  scaled result
- coef_active  out  COEF_W  coefficient currently applied to new samples
- sat_flag  out  1  sticky; set when any result was clamped

## Operation
- No backpressure. A sample is accepted on every cycle with in_valid=1.
- Coefficient handling:
  - On coef_load=1, the shadow register takes coef_in and a pending flag is set.
  - On the next cycle, the active coefficient takes the shadow value and pending clears.
  - Each sample captures the active coefficient in the cycle it is accepted.
  - If coef_load and in_valid are high in the same cycle, that sample uses the old coefficient. The first sample accepted one or more cycles later uses the new one.
  - Back-to-back coef_load pulses: the last one wins.
- bypass_en is sampled together with each sample and travels with it down the pipe. A bypassed result equals in_data bit-exactly and never saturates or sets sat_flag.
- Arithmetic:
  - Full product P = in_data × coef, width DATA_W+COEF_W, signed.
  - If FRAC_W>0, compute R = (P + 2^(FRAC_W-1)) >>> FRAC_W (round half toward +∞, arithmetic shift). If FRAC_W=0, R = P.
  - Saturate R to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- sat_flag is set on each saturating result with out_valid=1. It clears on sat_clr. If sat_clr and a new saturation occur in the same cycle, the flag ends up 1 (set wins).
- Reset values:
  - out_valid=0, out_data=0, sat_flag=0.
  - Shadow and active coefficients = 2^FRAC_W (1.0); pending=0.
  - All pipeline valid bits = 0.
- Reset mid-stream: all in-flight samples are discarded and no out_valid is issued for them. The first sample accepted after rst deasserts gets reset gain 1.0.

## Timing
- Fixed latency of 3 cycles from in_valid to out_valid:
  - S1 registers the sample, coefficient and bypass bit.
  - S2 registers the full product.
  - S3 registers the rounded, saturated result and the sat update.
- Throughput is 1 sample/cycle. Gaps in in_valid are reproduced exactly on out_valid.
- out_data holds its last value while out_valid=0.
- coef_active updates exactly 1 cycle after coef_load.
- sat_flag changes in the same cycle as the out_valid of the offending result.

## Structure
- The shared package gain_pkg holds:
  - default widths;
  - a function giving unity (1 << FRAC_W);
  - saturation limit constants derived from DATA_W.
- One sub-module, gain_round_sat: purely combinational. It takes the full-width product and provides rounding, shift and clamp, plus a sat indication. The S3 register lives in the parent.
- The multiplier is inferred as `*` across S1→S2 so that it can be retimed into DSP cascades.

## Test plan
- Gain 1.0 after reset, in_data=12345 → out_data=12345 with out_valid exactly 3 cycles later; sat_flag=0.
- coef_in=2^29 (0.5) loaded, then in_data=3 → 2 (1.5 rounds up). Then in_data=-3 → -1 (-1.5 rounds toward +∞).
- coef_in=2^31-1 (≈2.0), in_data=2^63-1 → out_data=2^63-1 and sat_flag=1. Then in_data=-2^63 → out_data=-2^63. sat_clr together with a saturating result → sat_flag stays 1.
- Continuous in_valid with coef_load (0.5) asserted in the same cycle as sample N=100 → sample N outputs 100 and sample N+1=100 outputs 50.
- bypass_en=1 with coef=2.0 and in_data=2^62 → out_data=2^62, sat_flag unchanged.
- rst pulsed for 1 cycle while 3 samples are in flight → no out_valid for them; coef_active=2^30 afterwards.
